// File: rtl/udp_image_tx_scheduler.sv
// Packetises one image from a FWFT byte FIFO into UDP stack requests, each led by a 4-byte header.
// All outputs registered; WAIT holds until a whole packet is buffered, so the payload never stalls.
module udp_image_tx_scheduler #(
  parameter int PAYLOAD_MAX = 1024,
  parameter int GAP_CYCLES  = 64,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] img_bytes,
  input  logic [11:0] src_level,
  input  logic [7:0]  src_data,
  output logic        src_rd,
  input  logic        udp_tx_ready,
  output logic        app_tx_data_request,
  input  logic        app_tx_ack,
  output logic        app_tx_data_valid,
  output logic [7:0]  app_tx_data,
  output logic [15:0] udp_data_length,
  output logic        busy,
  output logic        done,
  output logic [15:0] pkt_count
);

  localparam logic [10:0] PMAX     = 11'(PAYLOAD_MAX);
  localparam logic [15:0] TO_LAST  = 16'(ACK_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [7:0]  MARKER   = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_REQ, S_REQ_LOW, S_HDR, S_PAYLOAD, S_GAP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] remaining_q, remaining_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] pkt_count_q, pkt_count_d;
  logic [15:0] tmr_q, tmr_d;
  logic [1:0]  hidx_q, hidx_d;
  logic [10:0] bcnt_q, bcnt_d;
  logic        src_rd_q, src_rd_d;
  logic        req_q, req_d;
  logic        vld_q, vld_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] len_q, len_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [10:0] plen;
  logic [10:0] bcnt_inc;
  logic [7:0]  flags;

  always_comb begin
    plen     = (remaining_q < 32'(PAYLOAD_MAX)) ? remaining_q[10:0] : PMAX;
    bcnt_inc = bcnt_q + 11'd1;
    flags    = {6'd0, (remaining_q == {21'd0, plen}), (seq_q == 16'd0)};

    state_d     = state_q;
    remaining_d = remaining_q;
    seq_d       = seq_q;
    pkt_count_d = pkt_count_q;
    tmr_d       = tmr_q;
    hidx_d      = hidx_q;
    bcnt_d      = bcnt_q;
    src_rd_d    = src_rd_q;
    req_d       = req_q;
    vld_d       = vld_q;
    data_d      = data_q;
    len_d       = len_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          remaining_d = img_bytes;
          seq_d       = 16'd0;
          pkt_count_d = 16'd0;
          state_d     = (img_bytes == 32'd0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        len_d = {5'd0, plen} + 16'd4;
        if (({1'b0, plen} <= src_level) && udp_tx_ready) begin
          req_d   = 1'b1;
          tmr_d   = 16'd0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // ack takes priority over a simultaneous ready drop or timeout
        if (app_tx_ack) begin
          req_d   = 1'b0;
          vld_d   = 1'b1;
          data_d  = seq_q[15:8];
          hidx_d  = 2'd0;
          state_d = S_HDR;
        end else if (!udp_tx_ready) begin
          req_d   = 1'b0;
          state_d = S_WAIT;
        end else if (tmr_q == TO_LAST) begin
          req_d   = 1'b0;
          tmr_d   = 16'd0;
          state_d = S_REQ_LOW;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_REQ_LOW: begin
        if (udp_tx_ready) begin
          req_d   = 1'b1;
          state_d = S_REQ;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HDR: begin
        hidx_d = hidx_q + 2'd1;
        case (hidx_q)
          2'd0: data_d = seq_q[7:0];
          2'd1: data_d = flags;
          2'd2: begin
            data_d   = MARKER;
            src_rd_d = 1'b1;
          end
          default: begin
            data_d   = src_data;
            bcnt_d   = 11'd1;
            src_rd_d = (plen > 11'd1);
            state_d  = S_PAYLOAD;
          end
        endcase
      end
      S_PAYLOAD: begin
        // src_rd low here means the byte now on app_tx_data is the packet's last
        if (src_rd_q) begin
          data_d   = src_data;
          bcnt_d   = bcnt_inc;
          src_rd_d = (bcnt_inc < plen);
        end else begin
          vld_d       = 1'b0;
          data_d      = 8'd0;
          remaining_d = remaining_q - {21'd0, plen};
          seq_d       = seq_q + 16'd1;
          pkt_count_d = pkt_count_q + 16'd1;
          tmr_d       = 16'd0;
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        if (tmr_q == GAP_LAST) begin
          state_d = (remaining_q != 32'd0) ? S_WAIT : S_DONE;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= 32'd0;
      seq_q       <= 16'd0;
      pkt_count_q <= 16'd0;
      tmr_q       <= 16'd0;
      hidx_q      <= 2'd0;
      bcnt_q      <= 11'd0;
      src_rd_q    <= 1'b0;
      req_q       <= 1'b0;
      vld_q       <= 1'b0;
      data_q      <= 8'd0;
      len_q       <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      seq_q       <= seq_d;
      pkt_count_q <= pkt_count_d;
      tmr_q       <= tmr_d;
      hidx_q      <= hidx_d;
      bcnt_q      <= bcnt_d;
      src_rd_q    <= src_rd_d;
      req_q       <= req_d;
      vld_q       <= vld_d;
      data_q      <= data_d;
      len_q       <= len_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign src_rd              = src_rd_q;
  assign app_tx_data_request = req_q;
  assign app_tx_data_valid   = vld_q;
  assign app_tx_data         = data_q;
  assign udp_data_length     = len_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign pkt_count           = pkt_count_q;

endmodule
